// File: rtl/rfid_rx_controller.sv
// rfid_rx_controller: opens a cleared receive window on request, captures one packet on a packet_rdy rising edge, hands it over via valid/ready, then enforces a guard interval.
// Ports: UL_clock/reset (sync, active-high); start/abort requests; rx_enable/rx_reset receiver control;
// packet/packet_rdy from the receiver; pkt_data/pkt_valid/pkt_ready consumer handshake;
// busy, timeout and overrun status pulses. All outputs are registered.
// Build option: RFID_RX_TIMEOUT_EN enables the listen-window counter and the timeout pulse.
module rfid_rx_controller #(
  parameter int PKT_W          = 128,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic             UL_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             rx_enable,
  output logic             rx_reset,
  input  logic [PKT_W-1:0] packet,
  input  logic             packet_rdy,
  output logic [PKT_W-1:0] pkt_data,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic             busy,
  output logic             timeout,
  output logic             overrun
);
  typedef enum logic [2:0] {IDLE, CLEAR, LISTEN, DELIVER, GUARD} state_e;
  localparam int GW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(HOLDOFF_CYCLES - 1);
  state_e state_q, state_d;
  logic rdy_q, rdy_edge, expire, kill;
  logic [GW-1:0] guard_q, guard_d;
  logic [PKT_W-1:0] pkt_data_q, pkt_data_d;
  logic rx_enable_q, rx_reset_q, pkt_valid_q, busy_q;
  logic timeout_q, timeout_d, overrun_q, overrun_d;
  assign rdy_edge = packet_rdy & ~rdy_q;
  assign kill     = abort & (state_q != IDLE);
`ifdef RFID_RX_TIMEOUT_EN
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] win_q, win_d;
  assign expire = win_q == T_LAST;
  always_comb win_d = state_q != LISTEN ? '0 : expire ? win_q : win_q + 1'b1;
  always_ff @(posedge UL_clock) begin
    if (reset) win_q <= '0;
    else win_q <= win_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES != 0;
  assign expire = 1'b0;
`endif
  always_comb guard_d = state_q != GUARD ? '0 : guard_q == G_LAST ? guard_q : guard_q + 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? CLEAR : IDLE;
      CLEAR:   state_d = LISTEN;
      LISTEN:  state_d = rdy_edge ? DELIVER : expire ? GUARD : LISTEN;
      DELIVER: state_d = pkt_ready ? GUARD : DELIVER;
      GUARD:   state_d = guard_q == G_LAST ? IDLE : GUARD;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
    pkt_data_d = (state_q == LISTEN && rdy_edge && !kill) ? packet : pkt_data_q;
    // capture beats expiry, abort suppresses both status pulses
    timeout_d = state_q == LISTEN && expire && !rdy_edge && !kill;
    overrun_d = rdy_edge && state_q != LISTEN && !kill;
  end
  always_ff @(posedge UL_clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      guard_q     <= '0;
      pkt_data_q  <= '0;
      rx_enable_q <= 1'b0;
      rx_reset_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= packet_rdy;
      guard_q     <= guard_d;
      pkt_data_q  <= pkt_data_d;
      rx_enable_q <= state_d == LISTEN;
      rx_reset_q  <= state_d == CLEAR;
      pkt_valid_q <= state_d == DELIVER;
      busy_q      <= state_d != IDLE;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end
  assign rx_enable = rx_enable_q;
  assign rx_reset  = rx_reset_q;
  assign pkt_data  = pkt_data_q;
  assign pkt_valid = pkt_valid_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_rfid_rx_controller.sv
// tb_rfid_rx_controller: randomized transactions with expected events queued by the driver and checked by an independent monitor.
module tb_rfid_rx_controller;
  localparam int W = 128, T = 16, H = 4;
`ifdef RFID_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, packet_rdy = 1'b0, pkt_ready = 1'b0;
  logic [W-1:0] packet = '0;
  logic rx_enable, rx_reset, pkt_valid, busy, timeout, overrun;
  logic [W-1:0] pkt_data;
  int checks = 0, failures = 0, cyc = 0;
  bit mon_en = 1'b0;
  int q_rr[$], q_to[$], q_ovr[$], q_idle[$], q_en_s[$], q_en_l[$], q_val[$];
  logic [W-1:0] q_dat[$];
  logic en_p = 1'b0, val_p = 1'b0, busy_p = 1'b0;
  int en_start = 0;
  logic [W-1:0] cur = '0;

  rfid_rx_controller #(.PKT_W(W), .TIMEOUT_CYCLES(T), .HOLDOFF_CYCLES(H)) dut (
    .UL_clock(clk), .reset(reset), .start(start), .abort(abort),
    .rx_enable(rx_enable), .rx_reset(rx_reset), .packet(packet), .packet_rdy(packet_rdy),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .busy(busy), .timeout(timeout), .overrun(overrun));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    failures++;
    $display("FAIL unexpected_%s cycle %0d: got event, required none", name, cyc);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (rx_reset) begin
      if (q_rr.size() == 0) miss("rx_reset"); else chk("rx_reset_cycle", cyc, q_rr.pop_front());
    end
    if (timeout) begin
      if (q_to.size() == 0) miss("timeout"); else chk("timeout_cycle", cyc, q_to.pop_front());
    end
    if (overrun) begin
      if (q_ovr.size() == 0) miss("overrun"); else chk("overrun_cycle", cyc, q_ovr.pop_front());
    end
    if (rx_enable && !en_p) en_start = cyc;
    if (!rx_enable && en_p) begin
      if (q_en_s.size() == 0) miss("rx_enable_fall");
      else begin
        chk("rx_enable_rise", en_start, q_en_s.pop_front());
        chk("rx_enable_len", cyc - en_start, q_en_l.pop_front());
      end
    end
    if (pkt_valid && !val_p) begin
      if (q_val.size() == 0) miss("pkt_valid");
      else begin
        chk("valid_cycle", cyc, q_val.pop_front());
        cur = q_dat.pop_front();
        chk("pkt_data", pkt_data, cur);
      end
    end else if (pkt_valid) chk("pkt_data_hold", pkt_data, cur);
    if (busy && !busy_p) chk("busy_with_rx_reset", rx_reset, 1'b1);
    if (!busy && busy_p) begin
      if (q_idle.size() == 0) miss("busy_fall"); else chk("busy_fall_cycle", cyc, q_idle.pop_front());
    end
    en_p = rx_enable;
    val_p = pkt_valid;
    busy_p = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_to(input int c);
    while (cyc < c) begin
      start = 1'($urandom_range(0, 1));
      pkt_ready = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
  endtask

  // mode: 0 capture, 1 timeout/long listen, 2 abort with edge, 3 abort in CLEAR, 4 abort with handshake
  task automatic run_txn(input int mode, input int kf, input int bf, input logic [W-1:0] df, input bit use_df);
    int n, e, k, m, l, b;
    logic [W-1:0] d;
    if ($urandom_range(0, 3) == 0) begin
      packet = {$urandom, $urandom, $urandom, $urandom};
      packet_rdy = 1'b1;
      q_ovr.push_back(cyc + 1);
      tick();
      packet_rdy = 1'b0;
      tick();
    end
    n = cyc;
    start = 1'b1;
    q_rr.push_back(n + 1);
    tick();
    start = 1'($urandom_range(0, 1));
    if (mode == 3) begin
      abort = 1'b1;
      q_idle.push_back(n + 2);
      tick();
      abort = 1'b0;
      start = 1'b0;
      return;
    end
    tick();
    e = n + 2;
    if (mode == 1) begin
      if (TO_EN) begin
        q_en_s.push_back(e); q_en_l.push_back(T);
        q_to.push_back(e + T);
        q_idle.push_back(e + T + H);
        settle_to(e + T + H);
      end else begin
        settle_to(e + 40);
        abort = 1'b1;
        q_en_s.push_back(e); q_en_l.push_back(41);
        q_idle.push_back(e + 41);
        tick();
        abort = 1'b0;
      end
      return;
    end
    k = kf >= 0 ? kf : ($urandom_range(0, 3) == 0 ? (TO_EN ? T - 1 : 0) : $urandom_range(0, TO_EN ? T - 1 : 20));
    settle_to(e + k);
    m = cyc;
    d = use_df ? df : {$urandom, $urandom, $urandom, $urandom};
    packet = d;
    packet_rdy = 1'b1;
    q_en_s.push_back(e); q_en_l.push_back(k + 1);
    if (mode == 2) begin
      abort = 1'b1;
      q_idle.push_back(m + 1);
      tick();
      abort = 1'b0;
      packet_rdy = 1'b0;
      return;
    end
    q_val.push_back(m + 1);
    q_dat.push_back(d);
    b = bf >= 0 ? bf : ($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 10));
    pkt_ready = b == 0;
    tick();
    packet_rdy = 1'b0;
    packet = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < b; i++) begin
      pkt_ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      if (i == 1) begin
        packet_rdy = 1'b1;
        q_ovr.push_back(cyc + 1);
      end
      tick();
    end
    pkt_ready = 1'b1;
    start = 1'b0;
    l = cyc;
    if (mode == 4) begin
      abort = 1'b1;
      q_idle.push_back(l + 1);
      tick();
      abort = 1'b0;
      pkt_ready = 1'b0;
      packet_rdy = 1'b0;
      return;
    end
    q_idle.push_back(l + H + 1);
    tick();
    packet_rdy = 1'b0;
    pkt_ready = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 1) begin
      tick();
      packet_rdy = 1'b1;
      q_ovr.push_back(cyc + 1);
      tick();
      packet_rdy = 1'b0;
    end
    settle_to(l + H + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    int n;
    packet_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_rx_enable", rx_enable, 1'b0);
    chk("rst_rx_reset", rx_reset, 1'b0);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_pkt_data", pkt_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    mon_en = 1'b1;
    reset = 1'b0;
    repeat (2) tick();
    packet_rdy = 1'b0;
    tick();
    run_txn(0, 5, 0, {16{8'hA5}}, 1'b1);
    run_txn(1, -1, -1, '0, 1'b0);
    run_txn(0, 3, 10, {4{32'h12345678}}, 1'b1);
    run_txn(2, 4, -1, '0, 1'b0);
    run_txn(0, TO_EN ? T - 1 : 7, 1, '0, 1'b0);
    run_txn(4, 2, 0, '0, 1'b0);
    run_txn(3, -1, -1, '0, 1'b0);
    for (int i = 0; i < 40; i++) run_txn($urandom_range(0, 4), -1, -1, '0, 1'b0);
    n = cyc;
    start = 1'b1;
    q_rr.push_back(n + 1);
    tick();
    start = 1'b0;
    tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    packet = d;
    packet_rdy = 1'b1;
    q_en_s.push_back(cyc); q_en_l.push_back(1);
    q_val.push_back(cyc + 1); q_dat.push_back(d);
    pkt_ready = 1'b0;
    tick();
    reset = 1'b1;
    q_idle.push_back(cyc + 1);
    tick();
    chk("midrst_pkt_valid", pkt_valid, 1'b0);
    chk("midrst_pkt_data", pkt_data, '0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rx_enable", rx_enable, 1'b0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    packet_rdy = 1'b0;
    repeat (3) tick();
    chk("left_rx_reset", q_rr.size(), 0);
    chk("left_timeout", q_to.size(), 0);
    chk("left_overrun", q_ovr.size(), 0);
    chk("left_busy_fall", q_idle.size(), 0);
    chk("left_rx_enable", q_en_s.size(), 0);
    chk("left_pkt_valid", q_val.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rfid_rx_controller.md
# rfid_rx_controller

Sequencing controller for the uplink packet receiver. It opens a receive window on request and clears the receiver before each window. It captures the receiver's 128-bit packet on the rising edge of its ready flag and hands the packet to the command layer over a valid/ready handshake. A guard interval follows each window before the next one can open.

## Interface
- PKT_W, 128: packet width; must match the receiver's packet bus.
- TIMEOUT_CYCLES, 1024: length of the listen window in UL_clock cycles, ≥2.
- HOLDOFF_CYCLES, 8: guard interval after each window, ≥1.

Ports:
- UL_clock  in  1  uplink clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a receive window; sampled only in IDLE.
- abort  in  1  cancel the current window or delivery; returns to IDLE.
- rx_enable  out  1  receiver enable; high only in LISTEN.
- rx_reset  out  1  one-cycle clear pulse to the receiver; top level drives receiver reset_n = ~rx_reset & ~reset.
- packet  in  PKT_W  receiver packet bus.
- packet_rdy  in  1  receiver packet-ready level, same clock domain.
- pkt_data  out  PKT_W  captured packet; held stable while pkt_valid is high.
- pkt_valid  out  1  packet available to the consumer.
- pkt_ready  in  1  consumer accept.
- busy  out  1  high whenever state ≠ IDLE.
- timeout  out  1  one-cycle pulse when the window expires without a packet.
- overrun  out  1  one-cycle pulse when a packet_rdy rising edge arrives outside LISTEN; that packet is dropped.

## Operation
- Defined states: IDLE, CLEAR, LISTEN, DELIVER, GUARD.
- State behaviour and transitions:
  - IDLE: start=1 → CLEAR. No other transitions.
  - CLEAR: rx_reset=1 for exactly one cycle, then → LISTEN.
  - LISTEN: rx_enable=1. The window counter clears on entry and increments every cycle.
  - LISTEN, edge detected: an edge is packet_rdy=1 with registered rdy_q=0. On an edge, pkt_data ← packet, pkt_valid ← 1, → DELIVER.
  - LISTEN, counter expiry: counter = TIMEOUT_CYCLES-1 with no edge → timeout pulse, → GUARD.
  - DELIVER: pkt_valid=1 until the cycle where pkt_valid & pkt_ready. pkt_valid is low the following cycle, then → GUARD.
  - GUARD: counts HOLDOFF_CYCLES cycles, then → IDLE.
- rdy_q ← packet_rdy every cycle. Reset loads rdy_q=1, so a high level at reset release is not treated as an edge.
- Precedence and boundary rules:
  - Edge and counter expiry in the same cycle: capture wins, no timeout pulse.
  - start outside IDLE: ignored, not queued.
  - abort in any non-IDLE state: next state IDLE; pkt_valid and rx_enable low next cycle; no timeout or overrun pulse that cycle. Abort in IDLE has no effect.
  - abort together with an edge in LISTEN: abort wins, packet discarded, no overrun.
  - abort together with pkt_valid & pkt_ready: the transfer counts as complete; state → IDLE, skipping GUARD.
  - Edge in CLEAR, DELIVER, GUARD or IDLE: overrun pulse; pkt_data unchanged.
- Counters are sized $clog2 of their parameter and saturate at the terminal value. They never wrap.

## Timing
- Reset values: state IDLE, rx_enable=0, rx_reset=0, pkt_valid=0, pkt_data=0, busy=0, timeout=0, overrun=0, counters=0.
- Latency from start: start sampled at cycle N → rx_reset=1 and busy=1 at N+1 → rx_enable=1 at N+2.
- Capture latency: edge at cycle M → pkt_valid=1, pkt_data valid, rx_enable=0 at M+1.
- Window length: rx_enable is high for exactly TIMEOUT_CYCLES cycles. timeout pulses in the first cycle after rx_enable falls.
- Handshake: the consumer may hold pkt_ready high permanently; minimum DELIVER residency is 1 cycle.
- Guard timing: busy falls HOLDOFF_CYCLES cycles after the last DELIVER or LISTEN cycle. The earliest next start is sampled in that IDLE cycle.
- All outputs are registered.

## Configuration
- RFID_RX_TIMEOUT_EN defined: the window counter and timeout behave as specified above.
- RFID_RX_TIMEOUT_EN undefined:
  - LISTEN persists until an edge or abort.
  - The window counter is not instantiated.
  - timeout is tied 0 and TIMEOUT_CYCLES is ignored.

## Test plan
- Normal capture: reset, start pulse, packet_rdy rises 5 cycles into LISTEN with packet=128'hA5…A5, pkt_ready=1 → pkt_valid for 1 cycle with pkt_data=128'hA5…A5; busy low 8 cycles after handshake.
- Timeout (macro defined, TIMEOUT_CYCLES=16): start, no packet_rdy → rx_enable high exactly 16 cycles, one timeout pulse, no pkt_valid.
- Timeout (macro undefined): same stimulus for 100 cycles → rx_enable stays high, timeout stays 0.
- Backpressure: capture 128'h1234…, hold pkt_ready=0 for 10 cycles → pkt_valid and pkt_data stable for 10 cycles; a second packet_rdy edge in that interval → overrun pulse, pkt_data unchanged.
- Abort with simultaneous edge: abort and a packet_rdy edge in the same LISTEN cycle → IDLE next cycle, pkt_valid=0, overrun=0, timeout=0.
- Reset mid-operation: assert reset during DELIVER → all outputs 0 next cycle; packet_rdy held high through reset release → no capture and no overrun.
